// File: rtl/emissor_senha.sv
// Digit-sequence transmitter for the keypad side of the combination lock.
// Holds an N-digit BCD code (programmable digit by digit) and replays it
// as (numero, insere) strobes, one digit every GAP+1 cycles, most
// significant nibble first.
module emissor_senha #(
  parameter int                     N_DIGITOS  = 6,
  parameter int                     GAP        = 4,
  parameter logic [4*N_DIGITOS-1:0] CODIGO_RST = 24'h590281
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog,
  input  logic       grava,
  input  logic [3:0] digito_in,
  input  logic       inicia,
  output logic [3:0] numero,
  output logic       insere,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [2:0] indice
);

  localparam int       CW   = $clog2(GAP + 1);
  localparam logic [2:0] LAST = 3'(N_DIGITOS - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    PROGRAMA,
    ENVIA,
    ESPERA,
    FIM
  } estado_t;

  estado_t         estado_q;
  logic [3:0]      code_q   [N_DIGITOS];
  logic [3:0]      shadow_q [N_DIGITOS];
  logic [CW-1:0]   gap_q;
  logic [3:0]      numero_q;
  logic            insere_q;
  logic            ocupado_q;
  logic            pronto_q;
  logic            erro_q;
  logic [2:0]      indice_q;

  // Controller: programming, playback and all registered outputs.
  // NOTE: synchronous reset lives inside the clocked block; the code array is
  // reset too because it must come up holding CODIGO_RST, while every state
  // register uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q  <= OCIOSO;
      for (int j = 0; j < N_DIGITOS; j++) begin
        code_q[j]   <= CODIGO_RST[4*(N_DIGITOS-1-j) +: 4];
        shadow_q[j] <= 4'd0;
      end
      gap_q     <= '0;
      numero_q  <= 4'd0;
      insere_q  <= 1'b0;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      indice_q  <= 3'd0;
    end else begin
      // Pulse outputs default low every cycle.
      insere_q <= 1'b0;
      pronto_q <= 1'b0;
      erro_q   <= 1'b0;

      case (estado_q)
        OCIOSO: begin
          if (prog) begin
            estado_q  <= PROGRAMA;
            ocupado_q <= 1'b1;
            indice_q  <= 3'd0;
            for (int j = 0; j < N_DIGITOS; j++) shadow_q[j] <= 4'd0;
          end else if (inicia) begin
            estado_q <= ENVIA;
            indice_q <= 3'd0;
          end
        end

        PROGRAMA: begin
          if (!prog) begin
            // Abandoned programming: shadow is dropped, code is untouched.
            estado_q  <= OCIOSO;
            ocupado_q <= 1'b0;
            indice_q  <= 3'd0;
          end else if (grava) begin
            if (digito_in > 4'd9) begin
              erro_q <= 1'b1;
            end else if (indice_q == LAST) begin
              // Final digit goes straight into the code alongside the shadow.
              code_q       <= shadow_q;
              code_q[LAST] <= digito_in;
              pronto_q     <= 1'b1;
              ocupado_q    <= 1'b0;
              indice_q     <= 3'd0;
              estado_q     <= OCIOSO;
            end else begin
              shadow_q[indice_q] <= digito_in;
              indice_q           <= indice_q + 3'd1;
            end
          end
        end

        ENVIA: begin
          numero_q  <= code_q[indice_q];
          insere_q  <= 1'b1;
          ocupado_q <= 1'b1;
          gap_q     <= CW'(GAP);
          estado_q  <= ESPERA;
        end

        ESPERA: begin
          if (gap_q == CW'(1)) begin
            if (indice_q == LAST) begin
              estado_q <= FIM;
            end else begin
              indice_q <= indice_q + 3'd1;
              estado_q <= ENVIA;
            end
          end else begin
            gap_q <= gap_q - CW'(1);
          end
        end

        FIM: begin
          pronto_q  <= 1'b1;
          ocupado_q <= 1'b0;
          indice_q  <= 3'd0;
          estado_q  <= OCIOSO;
        end

        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign numero  = numero_q;
  assign insere  = insere_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;
  assign erro    = erro_q;
  assign indice  = indice_q;

endmodule

// File: tb/tb_emissor_senha.sv
// Self-checking bench for emissor_senha: a timeline model of the transmitter
// is compared against the DUT every cycle, and directed scenarios pin the
// model with hand-computed strobe timings and digit sequences.
module tb_emissor_senha;

  localparam int ND  = 6;
  localparam int G   = 4;
  localparam int PER = G + 1;

  logic       clk = 1'b0;
  logic       reset, prog, grava, inicia;
  logic [3:0] digito_in;
  logic [3:0] numero;
  logic       insere, ocupado, pronto, erro;
  logic [2:0] indice;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  emissor_senha #(.N_DIGITOS(ND), .GAP(G), .CODIGO_RST(24'h590281)) dut (
    .clk(clk), .reset(reset), .prog(prog), .grava(grava),
    .digito_in(digito_in), .inicia(inicia), .numero(numero),
    .insere(insere), .ocupado(ocupado), .pronto(pronto), .erro(erro),
    .indice(indice)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- timeline model ----------------
  typedef enum int {M_IDLE, M_PROG, M_PLAY} mode_t;
  mode_t      mode = M_IDLE;
  int         t;
  logic [3:0] m_code [ND];
  logic [3:0] m_sh [$];
  logic [3:0] e_numero;
  logic       e_insere, e_ocupado, e_pronto, e_erro;
  logic [2:0] e_indice;

  task automatic model_step();
    int slot;
    logic [3:0] rst_digits [ND];
    rst_digits = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd8, 4'd1};
    e_insere = 1'b0;
    e_pronto = 1'b0;
    e_erro   = 1'b0;
    if (!reset) begin
      mode = M_IDLE;
      m_code = rst_digits;
      m_sh.delete();
      e_numero = 4'd0; e_ocupado = 1'b0; e_indice = 3'd0;
    end else begin
      case (mode)
        M_IDLE: begin
          if (prog) begin
            mode = M_PROG; m_sh.delete(); e_ocupado = 1'b1; e_indice = 3'd0;
          end else if (inicia) begin
            mode = M_PLAY; t = 0; e_indice = 3'd0;
          end
        end
        M_PROG: begin
          if (!prog) begin
            mode = M_IDLE; e_ocupado = 1'b0; e_indice = 3'd0;
          end else if (grava) begin
            if (digito_in > 4'd9) e_erro = 1'b1;
            else begin
              m_sh.push_back(digito_in);
              if (m_sh.size() == ND) begin
                for (int i = 0; i < ND; i++) m_code[i] = m_sh[i];
                e_pronto = 1'b1; e_ocupado = 1'b0; e_indice = 3'd0; mode = M_IDLE;
              end else begin
                e_indice = 3'(m_sh.size());
              end
            end
          end
        end
        M_PLAY: begin
          t++;
          if (t == ND*PER + 1) begin
            e_pronto = 1'b1; e_ocupado = 1'b0; e_indice = 3'd0; mode = M_IDLE;
          end else begin
            slot = (t - 1) / PER;
            e_insere  = ((t - 1) % PER) == 0;
            e_numero  = m_code[slot];
            e_ocupado = 1'b1;
            e_indice  = 3'(((t / PER) < ND - 1) ? (t / PER) : ND - 1);
          end
        end
        default: mode = M_IDLE;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("numero",  32'(numero),  32'(e_numero));
      check("insere",  32'(insere),  32'(e_insere));
      check("ocupado", 32'(ocupado), 32'(e_ocupado));
      check("pronto",  32'(pronto),  32'(e_pronto));
      check("erro",    32'(erro),    32'(e_erro));
      check("indice",  32'(indice),  32'(e_indice));
      if (insere === 1'b1 && pronto === 1'b1) check("insere_pronto_excl", 32'(1), 32'(0));
    end
  end

  // Strobe collector for literal sequence checks.
  logic [3:0] got_d [$];
  int         got_c [$];
  initial forever begin
    @(negedge clk);
    if (insere === 1'b1) begin
      got_d.push_back(numero);
      got_c.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic prog_digit(input logic [3:0] d);
    digito_in = d;
    grava = 1'b1;
    @(negedge clk);
    grava = 1'b0;
  endtask

  task automatic play(output int t0, output int pc);
    got_d.delete();
    got_c.delete();
    inicia = 1'b1;
    @(negedge clk);
    t0 = cyc;
    inicia = 1'b0;
    pc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) begin
        pc = cyc;
        break;
      end
    end
    if (pc < 0) begin
      total++;
      bad++;
      $display("FAIL pronto_timeout: got none expected pulse within 60 cycles");
    end
  endtask

  task automatic check_seq(input string name, input logic [3:0] e [ND], input int t0, input int pc);
    check({name, "_count"}, 32'(got_d.size()), 32'(ND));
    for (int i = 0; i < ND && i < got_d.size(); i++) begin
      check({name, "_digit"}, 32'(got_d[i]), 32'(e[i]));
      check({name, "_when"},  32'(got_c[i] - t0), 32'(1 + i*PER));
    end
    check({name, "_pronto_when"}, 32'(pc - t0), 32'(31));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, pc, n;
    logic [3:0] exp_def [ND];
    logic [3:0] exp_pi  [ND];
    logic [3:0] exp_t3  [ND];
    exp_def = '{4'd5, 4'd9, 4'd0, 4'd2, 4'd8, 4'd1};
    exp_pi  = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9};
    exp_t3  = '{4'd7, 4'd2, 4'd4, 4'd6, 4'd8, 4'd0};

    reset = 1'b0; prog = 1'b0; grava = 1'b0; inicia = 1'b0; digito_in = 4'd0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_numero",  32'(numero),  32'(0));
    check("rst_insere",  32'(insere),  32'(0));
    check("rst_ocupado", 32'(ocupado), 32'(0));
    check("rst_indice",  32'(indice),  32'(0));
    reset = 1'b1;
    @(negedge clk);

    // 1: default code playback
    play(t0, pc);
    check_seq("t1", exp_def, t0, pc);
    @(negedge clk);

    // 4: aborted programming leaves the code untouched
    prog = 1'b1;
    @(negedge clk);
    prog_digit(4'd1); prog_digit(4'd2); prog_digit(4'd3);
    check("t4_indice", 32'(indice), 32'(3));
    prog = 1'b0;
    @(negedge clk);
    check("t4_pronto",  32'(pronto),  32'(0));
    check("t4_ocupado", 32'(ocupado), 32'(0));
    play(t0, pc);
    check_seq("t4", exp_def, t0, pc);
    @(negedge clk);

    // 6: prog wins over inicia
    inicia = 1'b1; prog = 1'b1;
    @(negedge clk);
    inicia = 1'b0;
    check("t6_ocupado", 32'(ocupado), 32'(1));
    @(negedge clk);
    check("t6_insere", 32'(insere), 32'(0));
    prog = 1'b0;
    @(negedge clk);
    check("t6_idle", 32'(ocupado), 32'(0));

    // 2: program 3,1,4,1,5,9 and replay
    prog = 1'b1;
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      prog_digit(exp_pi[i]);
      if (i == ND - 1) begin
        check("t2_pronto", 32'(pronto), 32'(1));
        prog = 1'b0;
      end else begin
        check("t2_indice", 32'(indice), 32'(i + 1));
      end
    end
    @(negedge clk);
    play(t0, pc);
    check_seq("t2", exp_pi, t0, pc);
    @(negedge clk);

    // 3: rejected digit in the middle of programming
    prog = 1'b1;
    @(negedge clk);
    prog_digit(4'd7);
    prog_digit(4'd12);
    check("t3_erro",   32'(erro),   32'(1));
    check("t3_indice", 32'(indice), 32'(1));
    for (int i = 1; i < ND; i++) prog_digit(exp_t3[i]);
    check("t3_pronto", 32'(pronto), 32'(1));
    prog = 1'b0;
    @(negedge clk);
    play(t0, pc);
    check_seq("t3", exp_t3, t0, pc);
    @(negedge clk);

    // 5: ignored commands mid-playback, then reset during the gap
    inicia = 1'b1;
    @(negedge clk);
    inicia = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (insere === 1'b1) n++;
    end
    check("t5_three_strobes", 32'(n), 32'(3));
    inicia = 1'b1; prog = 1'b1;
    @(negedge clk);
    inicia = 1'b0; prog = 1'b0;
    check("t5_still_busy", 32'(ocupado), 32'(1));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t5_rst_insere",  32'(insere),  32'(0));
    check("t5_rst_ocupado", 32'(ocupado), 32'(0));
    check("t5_rst_indice",  32'(indice),  32'(0));
    @(negedge clk);
    play(t0, pc);
    check_seq("t5", exp_def, t0, pc);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
